codeword_serializer: RTL and testbench

Downstream stage of the 64-to-128-bit block encoder. Captures each 128-bit encoded word on the encoder's start/done-style strobe and emits it as a stream of SYM_W-bit symbols over a valid/ready interface toward the modulator/line side. A one-word holding register lets the encoder deliver the next word while the current one drains, so back-to-back words stream with no bubbles.

---
 rtl/codeword_serializer.sv | 154 +++++++++++++++
 tb/tb_codeword_serializer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codeword_serializer.sv
// Drains 128-bit encoded words as SYM_W-bit symbols over valid/ready.
// Optional sync preamble before each word: define SER_PREAMBLE_EN.
module codeword_serializer #(
  parameter int          WORD_W    = 128,
  parameter int          SYM_W     = 2,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic [15:0] PREAMBLE  = 16'hF628
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic              in_ready,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic [SYM_W-1:0]  ser_data,
  output logic              ser_last,
  output logic              done,
  output logic              overflow
);

  localparam int N  = WORD_W / SYM_W;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef SER_PREAMBLE_EN
  localparam logic [1:0] S_PRE  = 2'd2;
  localparam logic [1:0] S_FIRST = S_PRE;
  localparam int NP = 16 / SYM_W;
  localparam int PW = $clog2(NP);
  localparam logic [PW-1:0] PLAST = PW'(NP - 1);
`else
  localparam logic [1:0] S_FIRST = S_SEND;
`endif

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_sr;
  logic [WORD_W-1:0] r_hr;
  logic              r_hold_full;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic              r_ovf;
`ifdef SER_PREAMBLE_EN
  logic [15:0]       r_pre;
  logic [PW-1:0]     r_pcnt;
`else
  logic              w_unused_pre;
  assign w_unused_pre = ^PREAMBLE;
`endif

  logic              w_acc;
  logic              w_xfer;
  logic              w_end;
  logic [SYM_W-1:0]  w_sym;
  logic [WORD_W-1:0] w_sr_shift;

  assign in_ready  = !r_hold_full;
  assign ser_valid = (r_state != S_IDLE);
  assign ser_last  = (r_state == S_SEND) && (r_cnt == LAST);
  assign done      = r_done;
  assign overflow  = r_ovf;

  assign w_acc  = start && !r_hold_full;
  assign w_xfer = ser_valid && ser_ready;
  assign w_end  = w_xfer && ser_last;

  assign w_sym = MSB_FIRST ? r_sr[WORD_W-1 -: SYM_W]
                           : r_sr[SYM_W-1:0];
  assign w_sr_shift = MSB_FIRST ? (r_sr << SYM_W)
                                : (r_sr >> SYM_W);

  always_comb begin
    ser_data = '0;
    if (r_state == S_SEND) ser_data = w_sym;
`ifdef SER_PREAMBLE_EN
    if (r_state == S_PRE) ser_data = r_pre[15 -: SYM_W];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_hr        <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef SER_PREAMBLE_EN
      r_pre       <= '0;
      r_pcnt      <= '0;
`endif
    end else begin
      r_done <= w_end;
      if (start && r_hold_full) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_sr    <= data_in;
            r_cnt   <= '0;
            r_state <= S_FIRST;
`ifdef SER_PREAMBLE_EN
            r_pre   <= PREAMBLE;
            r_pcnt  <= '0;
`endif
          end
        end
        S_SEND: begin
          if (w_end) begin
            r_cnt <= '0;
            // held word wins; an empty hold lets data_in go straight in
            if (r_hold_full || w_acc) begin
              r_sr        <= r_hold_full ? r_hr : data_in;
              r_hold_full <= 1'b0;
              r_state     <= S_FIRST;
`ifdef SER_PREAMBLE_EN
              r_pre       <= PREAMBLE;
              r_pcnt      <= '0;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            if (w_xfer) begin
              r_sr  <= w_sr_shift;
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_acc) begin
              r_hr        <= data_in;
              r_hold_full <= 1'b1;
            end
          end
        end
`ifdef SER_PREAMBLE_EN
        S_PRE: begin
          if (w_xfer) begin
            r_pre  <= r_pre << SYM_W;
            r_pcnt <= r_pcnt + 1'b1;
            if (r_pcnt == PLAST) r_state <= S_SEND;
          end
          if (w_acc) begin
            r_hr        <= data_in;
            r_hold_full <= 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codeword_serializer.sv
// Directed bench for codeword_serializer (MSB_FIRST=1, SYM_W=2).
// With SER_PREAMBLE_EN defined only the reset and preamble tests run.
module tb_codeword_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] data_in = '0;
  logic         in_ready;
  logic         ser_valid;
  logic         ser_ready = 1'b1;
  logic [1:0]   ser_data;
  logic         ser_last;
  logic         done;
  logic         overflow;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  logic [1:0] sym_q[$];
  bit         last_q[$];
  int         cyc_q[$];
  int         done_q[$];

  codeword_serializer dut (
    .clk(clk), .reset(reset), .start(start),
    .data_in(data_in), .in_ready(in_ready),
    .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_data(ser_data), .ser_last(ser_last),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ser_valid && ser_ready) begin
      sym_q.push_back(ser_data);
      last_q.push_back(ser_last);
      cyc_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] word_at(input int base);
    logic [127:0] w = '0;
    for (int i = 0; i < 64; i++)
      if (base + i < sym_q.size())
        w = {w[125:0], sym_q[base+i]};
    return w;
  endfunction

  function automatic int lasts_at(input int base);
    int n = 0;
    for (int i = 0; i < 64; i++)
      if (base + i < last_q.size() && last_q[base+i]) n++;
    return n;
  endfunction

  task automatic clear_q();
    sym_q.delete();
    last_q.delete();
    cyc_q.delete();
    done_q.delete();
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int k = 0; k < budget && done_q.size() < n; k++)
      @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++; if (in_ready !== 1'b1) begin errs++;
      $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    vec++; if (ser_valid !== 1'b0) begin errs++;
      $display("FAIL rst_valid: got %b exp 0", ser_valid); end
    vec++; if (ser_data !== 2'b00) begin errs++;
      $display("FAIL rst_data: got %b exp 00", ser_data); end
    vec++; if (ser_last !== 1'b0) begin errs++;
      $display("FAIL rst_last: got %b exp 0", ser_last); end
    vec++; if (done !== 1'b0) begin errs++;
      $display("FAIL rst_done: got %b exp 0", done); end
    vec++; if (overflow !== 1'b0) begin errs++;
      $display("FAIL rst_ovf: got %b exp 0", overflow); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [127:0] w = 128'hC0000000_00000000_00000000_00000001;
    int c;
    int bad = 0;
    clear_q();
    ser_ready = 1'b1;
    start = 1'b1; data_in = w; c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, 200);
    @(negedge clk);
    vec++; if (sym_q.size() !== 64) begin errs++;
      $display("FAIL single_count: got %0d exp 64", sym_q.size()); end
    vec++; if (cyc_q.size() == 0 || cyc_q[0] !== c + 1) begin errs++;
      $display("FAIL single_latency: got %0d exp %0d",
               cyc_q.size() ? cyc_q[0] : -1, c + 1); end
    vec++; if (sym_q.size() == 0 || sym_q[0] !== 2'b11) begin errs++;
      $display("FAIL single_sym0: got %b exp 11",
               sym_q.size() ? sym_q[0] : 2'bxx); end
    for (int i = 1; i < 63 && i < sym_q.size(); i++)
      if (sym_q[i] !== 2'b00) bad++;
    vec++; if (bad !== 0) begin errs++;
      $display("FAIL single_mid: got %0d nonzero exp 0", bad); end
    vec++; if (sym_q.size() < 64 || sym_q[63] !== 2'b01) begin errs++;
      $display("FAIL single_sym63: got %b exp 01",
               sym_q.size() >= 64 ? sym_q[63] : 2'bxx); end
    vec++; if (last_q.size() < 64 || last_q[63] !== 1'b1 ||
               lasts_at(0) !== 1) begin errs++;
      $display("FAIL single_last: got %0d lasts exp 1 at 63",
               lasts_at(0)); end
    vec++; if (done_q.size() !== 1 || done_q[0] !== c + 65) begin errs++;
      $display("FAIL single_done: got %0d exp %0d",
               done_q.size() ? done_q[0] : -1, c + 65); end
    vec++; if (ser_valid !== 1'b0) begin errs++;
      $display("FAIL single_idle: got %b exp 0", ser_valid); end
    vec++; if (word_at(0) !== w) begin errs++;
      $display("FAIL single_word: got %h exp %h", word_at(0), w); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a = 128'h123456789ABCDEF0_0F0F0F0F0F0F0F0F;
    logic [127:0] b = 128'hFEDCBA9876543210_F0F0F0F0F0F0F0F0;
    int c;
    int lo = 0;
    int gaps = 0;
    clear_q();
    ser_ready = 1'b1;
    start = 1'b1; data_in = a; c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++;
      $display("FAIL b2b_ready_pre: got %b exp 1", in_ready); end
    start = 1'b1; data_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    vec++; if (in_ready !== 1'b0) begin errs++;
      $display("FAIL b2b_ready_held: got %b exp 0", in_ready); end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!in_ready) lo++;
      if (done_q.size() >= 2) break;
    end
    vec++; if (lo !== 54) begin errs++;
      $display("FAIL b2b_ready_low: got %0d cycles exp 54", lo); end
    vec++; if (sym_q.size() !== 128) begin errs++;
      $display("FAIL b2b_count: got %0d exp 128", sym_q.size()); end
    for (int i = 0; i < cyc_q.size(); i++)
      if (cyc_q[i] !== c + 1 + i) gaps++;
    vec++; if (gaps !== 0) begin errs++;
      $display("FAIL b2b_bubble: got %0d gaps exp 0", gaps); end
    vec++; if (word_at(0) !== a) begin errs++;
      $display("FAIL b2b_word0: got %h exp %h", word_at(0), a); end
    vec++; if (word_at(64) !== b) begin errs++;
      $display("FAIL b2b_word1: got %h exp %h", word_at(64), b); end
    vec++; if (lasts_at(0) !== 1 || lasts_at(64) !== 1 ||
               last_q.size() < 128 || !last_q[63] || !last_q[127])
      begin errs++;
      $display("FAIL b2b_last: got %0d/%0d exp 1/1",
               lasts_at(0), lasts_at(64)); end
    vec++; if (done_q.size() !== 2 || done_q[0] !== c + 65 ||
               done_q[1] !== c + 129) begin errs++;
      $display("FAIL b2b_done: got %0d pulses first %0d exp 2 at %0d",
               done_q.size(), done_q.size() ? done_q[0] : -1, c + 65);
    end
  endtask

  task automatic test_stall();
    logic [127:0] w = 128'h0123456789ABCDEF_FEDCBA9876543210;
    logic [1:0] p_data = '0;
    logic       p_last = 1'b0;
    logic       p_stall = 1'b0;
    int unstable = 0;
    clear_q();
    ser_ready = 1'b0;
    start = 1'b1; data_in = w;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 800 && done_q.size() < 1; k++) begin
      ser_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (p_stall && (ser_valid !== 1'b1 || ser_data !== p_data ||
                      ser_last !== p_last)) unstable++;
      p_stall = ser_valid && !ser_ready;
      p_data  = ser_data;
      p_last  = ser_last;
      @(posedge clk); #1;
    end
    ser_ready = 1'b1;
    vec++; if (unstable !== 0) begin errs++;
      $display("FAIL stall_stable: got %0d changes exp 0", unstable); end
    vec++; if (sym_q.size() !== 64) begin errs++;
      $display("FAIL stall_count: got %0d exp 64", sym_q.size()); end
    vec++; if (word_at(0) !== w) begin errs++;
      $display("FAIL stall_word: got %h exp %h", word_at(0), w); end
    vec++; if (lasts_at(0) !== 1 || last_q.size() < 64 || !last_q[63])
      begin errs++;
      $display("FAIL stall_last: got %0d exp 1", lasts_at(0)); end
  endtask

  task automatic test_overflow();
    logic [127:0] x = {8{16'h1111}};
    logic [127:0] y = {8{16'h2222}};
    logic [127:0] z = {8{16'h3333}};
    clear_q();
    ser_ready = 1'b1;
    start = 1'b1; data_in = x;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; data_in = y;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vec++; if (in_ready !== 1'b0 || overflow !== 1'b0) begin errs++;
      $display("FAIL ovf_pre: got rdy %b ovf %b exp 0 0",
               in_ready, overflow); end
    start = 1'b1; data_in = z;
    @(posedge clk); #1;
    start = 1'b0;
    vec++; if (overflow !== 1'b1) begin errs++;
      $display("FAIL ovf_set: got %b exp 1", overflow); end
    wait_done(2, 400);
    repeat (80) @(posedge clk);
    @(negedge clk);
    vec++; if (overflow !== 1'b1) begin errs++;
      $display("FAIL ovf_sticky: got %b exp 1", overflow); end
    vec++; if (sym_q.size() !== 128 || done_q.size() !== 2) begin errs++;
      $display("FAIL ovf_count: got %0d syms %0d dones exp 128 2",
               sym_q.size(), done_q.size()); end
    vec++; if (word_at(0) !== x || word_at(64) !== y) begin errs++;
      $display("FAIL ovf_words: got %h %h exp %h %h",
               word_at(0), word_at(64), x, y); end
  endtask

  task automatic test_midreset();
    logic [127:0] v = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    logic [127:0] h = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
    logic [127:0] q = 128'h80000000_00000000_00000000_00000003;
    int c;
    clear_q();
    ser_ready = 1'b1;
    start = 1'b1; data_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; data_in = h;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    vec++; if (sym_q.size() !== 20) begin errs++;
      $display("FAIL mrst_pos: got %0d exp 20", sym_q.size()); end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    vec++; if (ser_valid !== 1'b0 || ser_data !== 2'b00 ||
               ser_last !== 1'b0 || done !== 1'b0 ||
               in_ready !== 1'b1 || overflow !== 1'b0) begin errs++;
      $display("FAIL mrst_outs: got v%b d%b l%b dn%b r%b o%b exp 0 00 0 0 1 0",
               ser_valid, ser_data, ser_last, done, in_ready, overflow);
    end
    clear_q();
    repeat (80) @(posedge clk);
    #1;
    vec++; if (sym_q.size() !== 0 || done_q.size() !== 0) begin errs++;
      $display("FAIL mrst_discard: got %0d syms %0d dones exp 0 0",
               sym_q.size(), done_q.size()); end
    start = 1'b1; data_in = q; c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, 200);
    vec++; if (sym_q.size() !== 64 || word_at(0) !== q) begin errs++;
      $display("FAIL mrst_new: got %0d syms %h exp 64 %h",
               sym_q.size(), word_at(0), q); end
    vec++; if (cyc_q.size() == 0 || cyc_q[0] !== c + 1 ||
               done_q.size() !== 1 || done_q[0] !== c + 65) begin errs++;
      $display("FAIL mrst_timing: got first %0d done %0d exp %0d %0d",
               cyc_q.size() ? cyc_q[0] : -1,
               done_q.size() ? done_q[0] : -1, c + 1, c + 65); end
  endtask

  task automatic test_preamble();
    logic [127:0] w = 128'hC0000000_00000000_00000000_00000001;
    logic [15:0]  pre = 16'hF628;
    logic [15:0]  got = '0;
    int c;
    clear_q();
    ser_ready = 1'b1;
    start = 1'b1; data_in = w; c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, 300);
    for (int i = 0; i < 8 && i < sym_q.size(); i++)
      got = {got[13:0], sym_q[i]};
    vec++; if (sym_q.size() !== 72) begin errs++;
      $display("FAIL pre_count: got %0d exp 72", sym_q.size()); end
    vec++; if (got !== pre) begin errs++;
      $display("FAIL pre_pattern: got %h exp %h", got, pre); end
    vec++; if (lasts_at(8) !== 1 || lasts_at(0) !== 0 ||
               last_q.size() < 72 || !last_q[71]) begin errs++;
      $display("FAIL pre_last: got %0d in preamble exp 0",
               lasts_at(0)); end
    vec++; if (word_at(8) !== w) begin errs++;
      $display("FAIL pre_word: got %h exp %h", word_at(8), w); end
    vec++; if (done_q.size() !== 1 || done_q[0] !== c + 73) begin errs++;
      $display("FAIL pre_done: got %0d exp %0d",
               done_q.size() ? done_q[0] : -1, c + 73); end
  endtask

  initial begin
    test_reset();
`ifdef SER_PREAMBLE_EN
    test_preamble();
`else
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_midreset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
